dram_ctrl: RTL and testbench

Initiator-side controller for the team's multiplexed-address DRAM model. It turns single-word host read/write requests into row/column strobe sequences: row on /RAS fall, column on /CAS fall, then a one-cycle /WR or /RD strobe. It also issues periodic RAS-only refresh cycles. It sits between a CPU or bus arbiter and a DRAM instance with matching dw/aw/rw/cw/ctop/cbot.

---
 rtl/dram_ctrl_pkg.sv | 33 +++
 rtl/dram_refresh_timer.sv | 33 +++
 rtl/dram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared state encoding and address-mux helpers for the DRAM initiator.
package dram_ctrl_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;
  localparam logic [2:0] ST_REF  = 3'd6;

  // Helpers work on a wide scratch width; callers cast to their pin width.
  localparam int unsigned HLP_W = 64;

  function automatic logic [HLP_W-1:0] row_of(input logic [HLP_W-1:0] addr,
                                              input int unsigned     rw);
    logic [HLP_W-1:0] mask;
    mask = (HLP_W'(1) << rw) - HLP_W'(1);
    return addr & mask;
  endfunction

  function automatic logic [HLP_W-1:0] col_place(input logic [HLP_W-1:0] addr,
                                                 input int unsigned     rw,
                                                 input int unsigned     fw,
                                                 input int unsigned     lsb);
    logic [HLP_W-1:0] mask;
    mask = (HLP_W'(1) << fw) - HLP_W'(1);
    return ((addr >> rw) & mask) << lsb;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pend on every wrap.
module dram_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 256
) (
  input  logic i_MCLK,
  input  logic i_RST_n,
  input  logic ref_clr,
  output logic ref_pend
);

  localparam int unsigned CNT_W = $clog2(REF_INTERVAL);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = (cnt == CNT_W'(REF_INTERVAL - 1));

  // A wrap coinciding with a clear is a fresh request, so set wins.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
    end else begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      if (wrap_c) begin
        ref_pend <= 1'b1;
      end else if (ref_clr) begin
        ref_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Host-to-DRAM initiator: row/column strobe sequencing plus RAS-only refresh.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned dw           = 8,
  parameter int unsigned aw           = 8,
  parameter int unsigned rw           = aw,
  parameter int unsigned cw           = aw,
  parameter int unsigned ctop         = cw - 1,
  parameter int unsigned cbot         = 0,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RAS_REF    = 3,
  parameter int unsigned REF_INTERVAL = 256
) (
  input  logic             i_MCLK,
  input  logic             i_RST_n,
  input  logic             i_REQ,
  input  logic             i_WE,
  input  logic [rw+cw-1:0] i_ADDR,
  input  logic [dw-1:0]    i_WDATA,
  output logic             o_READY,
  output logic             o_ACK,
  output logic [dw-1:0]    o_RDATA,
  output logic [aw-1:0]    o_DRAM_ADDR,
  output logic             o_RAS_n,
  output logic             o_CAS_n,
  output logic             o_WR_n,
  output logic             o_RD_n,
  output logic [dw-1:0]    o_DRAM_DIN,
  input  logic [dw-1:0]    i_DRAM_DOUT
);

  localparam int unsigned AW_IN = rw + cw;
  localparam int unsigned T_MAX = (T_RP > T_RAS_REF) ? T_RP : T_RAS_REF;
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  logic [ST_W-1:0]  state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [AW_IN-1:0] addr_q;
  logic             we_q;
  logic [dw-1:0]    wdata_q;
  logic [rw-1:0]    ref_row;
  logic             ref_pend;
  logic             ref_clr_c, ref_inc_c, accept_c, to_pre_c;
  logic             ras_d, cas_d, wr_d, rd_d, ack_d;
  logic [aw-1:0]    addr_d, row_pins_c, col_pins_c;
  logic [dw-1:0]    din_d, rdata_d;

  assign o_READY    = (state == ST_IDLE) && !ref_pend;
  assign accept_c   = i_REQ && o_READY;
  assign row_pins_c = aw'(row_of(HLP_W'(i_ADDR), rw));
  assign col_pins_c = aw'(col_place(HLP_W'(addr_q), rw, ctop - cbot + 1, cbot));

  dram_refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .i_MCLK   (i_MCLK),
    .i_RST_n  (i_RST_n),
    .ref_clr  (ref_clr_c),
    .ref_pend (ref_pend)
  );

  // Next state and next value of every registered DRAM-side output.
  // PRE holds T_RP-1 cycles; the IDLE cycle that samples the next request
  // completes the T_RP-cycle precharge window.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ras_d     = 1'b1;
    cas_d     = 1'b1;
    wr_d      = 1'b1;
    rd_d      = 1'b1;
    ack_d     = 1'b0;
    addr_d    = o_DRAM_ADDR;
    din_d     = o_DRAM_DIN;
    rdata_d   = o_RDATA;
    ref_clr_c = 1'b0;
    ref_inc_c = 1'b0;
    to_pre_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ref_pend) begin
          state_d   = ST_REF;
          cnt_d     = CNT_W'(T_RAS_REF - 1);
          ras_d     = 1'b0;
          addr_d    = aw'(ref_row);
          ref_clr_c = 1'b1;
        end else if (accept_c) begin
          state_d = ST_ROW;
          ras_d   = 1'b0;
          addr_d  = row_pins_c;
        end
      end
      ST_ROW: begin
        state_d = ST_COL;
        ras_d   = 1'b0;
        cas_d   = 1'b0;
        addr_d  = col_pins_c;
      end
      ST_COL: begin
        state_d = ST_ACC;
        ras_d   = 1'b0;
        cas_d   = 1'b0;
        if (we_q) begin
          wr_d  = 1'b0;
          din_d = wdata_q;
        end else begin
          rd_d = 1'b0;
        end
      end
      ST_ACC: begin
        state_d = ST_DONE;
        ras_d   = 1'b0;
        cas_d   = 1'b0;
      end
      ST_DONE: begin
        ack_d    = 1'b1;
        to_pre_c = 1'b1;
        if (!we_q) begin
          rdata_d = i_DRAM_DOUT;
        end
      end
      ST_REF: begin
        if (cnt == '0) begin
          ref_inc_c = 1'b1;
          to_pre_c  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
          ras_d = 1'b0;
        end
      end
      ST_PRE: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_pre_c) begin
      if (T_RP > 1) begin
        state_d = ST_PRE;
        cnt_d   = CNT_W'(T_RP - 2);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ref_row     <= '0;
      o_RAS_n     <= 1'b1;
      o_CAS_n     <= 1'b1;
      o_WR_n      <= 1'b1;
      o_RD_n      <= 1'b1;
      o_ACK       <= 1'b0;
      o_RDATA     <= '0;
      o_DRAM_ADDR <= '0;
      o_DRAM_DIN  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      if (accept_c) begin
        addr_q  <= i_ADDR;
        we_q    <= i_WE;
        wdata_q <= i_WDATA;
      end
      if (ref_inc_c) begin
        ref_row <= ref_row + rw'(1);
      end
      o_RAS_n     <= ras_d;
      o_CAS_n     <= cas_d;
      o_WR_n      <= wr_d;
      o_RD_n      <= rd_d;
      o_ACK       <= ack_d;
      o_RDATA     <= rdata_d;
      o_DRAM_ADDR <= addr_d;
      o_DRAM_DIN  <= din_d;
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a behavioural multiplexed-address DRAM.
module tb_dram_ctrl;

  localparam int unsigned RI = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        ready, ack, ras_n, cas_n, wr_n, rd_n;
  logic [7:0]  rdata, dram_addr, din;
  logic [7:0]  dram_dout = '0;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          ecnt;
  int          ack_cnt = 0;
  int          run = 0;
  logic [7:0]  ref_q[$];

  logic [7:0]  mem [0:65535];
  logic [7:0]  row_q = '0, col_q = '0;
  logic        ras_prev = 1'b1, cas_prev = 1'b1;

  always #5 clk = ~clk;

  dram_ctrl #(
    .dw(8), .aw(8), .rw(8), .cw(8), .ctop(7), .cbot(0),
    .T_RP(2), .T_RAS_REF(3), .REF_INTERVAL(RI)
  ) dut (
    .i_MCLK      (clk),
    .i_RST_n     (rst_n),
    .i_REQ       (req),
    .i_WE        (we),
    .i_ADDR      (addr),
    .i_WDATA     (wdata),
    .o_READY     (ready),
    .o_ACK       (ack),
    .o_RDATA     (rdata),
    .o_DRAM_ADDR (dram_addr),
    .o_RAS_n     (ras_n),
    .o_CAS_n     (cas_n),
    .o_WR_n      (wr_n),
    .o_RD_n      (rd_n),
    .o_DRAM_DIN  (din),
    .i_DRAM_DOUT (dram_dout)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Edges since reset release; the DUT timer wraps on every RI-th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Multiplexed-address DRAM: row on /RAS fall, column on /CAS fall.
  always @(posedge clk) begin
    ras_prev <= ras_n;
    cas_prev <= cas_n;
    if (!ras_n && ras_prev) row_q <= dram_addr;
    if (!cas_n && cas_prev) col_q <= dram_addr;
    if (!wr_n) mem[{col_q, row_q}] <= din;
    if (!rd_n) dram_dout <= mem[{col_q, row_q}];
  end

  // Strobe invariants, ACK count and refresh-row log (second REF cycle).
  always @(negedge clk) begin
    check_eq("wr_rd_excl", 32'(!wr_n && !rd_n), 0);
    check_eq("cas_without_ras", 32'(!cas_n && ras_n), 0);
    if (ack) ack_cnt++;
    if (!ras_n && cas_n) run++;
    else run = 0;
    if (run == 2) ref_q.push_back(dram_addr);
  end

  task automatic wait_until(input int e);
    int n = 0;
    while (ecnt < e && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("schedule", 32'(ecnt), 32'(e));
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
    int n = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("accept_wait", 32'(ready), 1);
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (!ack && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
  endtask

  initial begin
    int lat, k, acks0, nb, tgt;
    logic [7:0] rd;
    int acc_e[3];
    logic [15:0] t2_addr[3];
    logic [7:0]  t2_data[3];
    t2_addr[0] = 16'h0110; t2_addr[1] = 16'h0220; t2_addr[2] = 16'h0330;
    t2_data[0] = 8'h11;    t2_data[1] = 8'h22;    t2_data[2] = 8'h33;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ras", 32'(ras_n), 1);
    check_eq("rst_cas", 32'(cas_n), 1);
    check_eq("rst_wr", 32'(wr_n), 1);
    check_eq("rst_rd", 32'(rd_n), 1);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_rdata", 32'(rdata), 0);
    check_eq("rst_addr", 32'(dram_addr), 0);
    check_eq("rst_din", 32'(din), 0);
    check_eq("rst_ready", 32'(ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write 0xA5 to {col=0x12,row=0x34}, cycle by cycle
    wait_until(2);
    req = 1'b1; we = 1'b1; addr = 16'h1234; wdata = 8'hA5;
    @(negedge clk);
    check_eq("t1_ready", 32'(ready), 1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check_eq("t1_row_ras", 32'(ras_n), 0);
    check_eq("t1_row_cas", 32'(cas_n), 1);
    check_eq("t1_row_addr", 32'(dram_addr), 32'h34);
    @(negedge clk);
    check_eq("t1_col_cas", 32'(cas_n), 0);
    check_eq("t1_col_addr", 32'(dram_addr), 32'h12);
    check_eq("t1_col_wr", 32'(wr_n), 1);
    @(negedge clk);
    check_eq("t1_acc_wr", 32'(wr_n), 0);
    check_eq("t1_acc_din", 32'(din), 32'hA5);
    @(negedge clk);
    check_eq("t1_done_wr", 32'(wr_n), 1);
    check_eq("t1_done_cas", 32'(cas_n), 0);
    @(negedge clk);
    check_eq("t1_ack", 32'(ack), 1);
    check_eq("t1_pre_ras", 32'(ras_n), 1);
    check_eq("t1_pre_ready", 32'(ready), 0);
    @(negedge clk);
    check_eq("t1_ack_pulse", 32'(ack), 0);
    check_eq("t1_idle_ready", 32'(ready), 1);

    access(1'b0, 16'h1234, 8'h00, lat, rd);
    check_eq("t1_rd_latency", 32'(lat), 4);
    check_eq("t1_rd_data", 32'(rd), 32'hA5);

    // Three back-to-back writes with i_REQ held
    wait_until(20);
    acks0 = ack_cnt;
    req = 1'b1; we = 1'b1; addr = t2_addr[0]; wdata = t2_data[0];
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(negedge clk);
      if (ready) begin
        acc_e[k] = ecnt + 1;
        k++;
        @(posedge clk); #1;
        if (k < 3) begin
          addr = t2_addr[k]; wdata = t2_data[k];
        end else begin
          req = 1'b0;
        end
      end
    end
    check_eq("t2_accepts", 32'(k), 3);
    check_eq("t2_space01", 32'(acc_e[1] - acc_e[0]), 6);
    check_eq("t2_space12", 32'(acc_e[2] - acc_e[1]), 6);
    wait_until(45);
    check_eq("t2_acks", 32'(ack_cnt - acks0), 3);
    for (int i = 0; i < 3; i++) check_eq("t2_mem", 32'(mem[t2_addr[i]]), 32'(t2_data[i]));

    // Timer wrap on the same edge the request appears in IDLE
    wait_until(RI);
    req = 1'b1; we = 1'b0; addr = 16'h0220;
    check_eq("t3_ready_blocked", 32'(ready), 0);
    for (int e = RI + 1; e <= RI + 3; e++) begin
      wait_until(e);
      check_eq("t3_ref_ras", 32'(ras_n), 0);
      check_eq("t3_ref_cas", 32'(cas_n), 1);
      check_eq("t3_ref_row", 32'(dram_addr), 0);
      check_eq("t3_ref_noack", 32'(ack), 0);
    end
    wait_until(RI + 4);
    check_eq("t3_pre_ras", 32'(ras_n), 1);
    wait_until(RI + 5);
    check_eq("t3_ready_after", 32'(ready), 1);
    check_eq("t3_not_yet", 32'(ras_n), 1);
    wait_until(RI + 6);
    check_eq("t3_accept_ras", 32'(ras_n), 0);
    check_eq("t3_accept_row", 32'(dram_addr), 32'h20);
    req = 1'b0;
    wait_until(RI + 10);
    check_eq("t3_ack", 32'(ack), 1);
    check_eq("t3_rdata", 32'(rdata), 32'h22);

    // Refresh wrap during an access (wrap edge lands in ACC)
    wait_until(2 * RI - 3);
    req = 1'b1; we = 1'b1; addr = 16'h5678; wdata = 8'h3C;
    wait_until(2 * RI - 2);
    check_eq("t6_row", 32'(dram_addr), 32'h78);
    req = 1'b0;
    wait_until(2 * RI + 2);
    check_eq("t6_ack", 32'(ack), 1);
    wait_until(2 * RI + 3);
    check_eq("t6_ready_blocked", 32'(ready), 0);
    check_eq("t6_pre_ras", 32'(ras_n), 1);
    wait_until(2 * RI + 4);
    check_eq("t6_ref_ras", 32'(ras_n), 0);
    check_eq("t6_ref_cas", 32'(cas_n), 1);
    check_eq("t6_ref_row", 32'(dram_addr), 1);
    check_eq("t6_mem", 32'(mem[16'h5678]), 32'h3C);

    // Full ref_row sweep with no host traffic
    wait_until(2 * RI + 12);
    acks0 = ack_cnt;
    k = 0;
    while (ref_q.size() < 257 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("sweep_count", 32'(ref_q.size() >= 257), 1);
    for (int i = 0; i < ref_q.size(); i++) check_eq("sweep_row", 32'(ref_q[i]), 32'(i % 256));
    check_eq("sweep_noack", 32'(ack_cnt - acks0), 0);

    // Reset asserted in ACC
    tgt = (ecnt / RI + 1) * RI + 10;
    wait_until(tgt);
    req = 1'b1; we = 1'b1; addr = 16'h0A0B; wdata = 8'h77;
    wait_until(tgt + 3);
    check_eq("t5_in_acc", 32'(wr_n), 0);
    req = 1'b0;
    acks0 = ack_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_ras", 32'(ras_n), 1);
    check_eq("t5_async_cas", 32'(cas_n), 1);
    check_eq("t5_async_wr", 32'(wr_n), 1);
    check_eq("t5_async_rd", 32'(rd_n), 1);
    check_eq("t5_idle", 32'(ready), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("t5_noack", 32'(ack_cnt - acks0), 0);
    nb = ref_q.size();
    access(1'b1, 16'h0C0D, 8'h5A, lat, rd);
    check_eq("t5_wr_latency", 32'(lat), 4);
    access(1'b0, 16'h0C0D, 8'h00, lat, rd);
    check_eq("t5_rd_latency", 32'(lat), 4);
    check_eq("t5_rd_data", 32'(rd), 32'h5A);
    wait_until(RI + 6);
    check_eq("t5_ref_count", 32'(ref_q.size()), 32'(nb + 1));
    if (ref_q.size() > nb) check_eq("t5_ref_row0", 32'(ref_q[nb]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
